nn_weight_update: RTL

Downstream consumer of the backprop node's stochastic gradient bitstreams (per-input dC/dalpha bits and one dC/dbeta bit).
- Integrates those bitstreams over a fixed sample window into signed up/down counts.
- At window end, applies a scaled gradient-descent step to a register bank of unipolar NB-bit weights (NN alpha, one beta).
- The weight bank feeds the forward-pass stochastic number generators.

---
 rtl/nn_weight_update.sv | 119 +++++++++++
 1 files changed

// File: rtl/nn_weight_update.sv
// Gradient-descent weight bank: integrates stochastic gradient bitstreams over a
// fixed window, then applies a shifted, saturated step to every weight at once.
module nn_weight_update #(
    parameter int          NB       = 16,
    parameter int          NN       = 3,
    parameter int          WIN_LOG2 = 8,
    parameter int          LR_SHIFT = 4,
    parameter int unsigned W_INIT   = 2 ** (NB - 1)
) (
    input  logic                CLK,
    input  logic                INIT,
    input  logic                TRAIN,
    input  logic [NN-1:0]       dalpha,
    input  logic                dbeta,
    input  logic                dsign,
    output logic [NN*NB-1:0]    alpha,
    output logic [NB-1:0]       beta,
    output logic                upd_valid,
    output logic                busy
);

    localparam int CW = WIN_LOG2 + 2;
    localparam int WW = NB + 2;
    localparam int NW = NN + 1;
    localparam logic [NB-1:0]       W_RST    = NB'(W_INIT);
    localparam logic [WIN_LOG2-1:0] WIN_LAST = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        APPLY = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [WIN_LOG2-1:0] win_reg;
    logic                upd_valid_reg;
    logic                busy_reg;
    logic [NW-1:0]       grad_bits;
    logic                count_en;
    logic                apply_en;

    assign grad_bits = {dbeta, dalpha};
    assign count_en  = (state_reg == ACCUM) && TRAIN;
    assign apply_en  = (state_reg == APPLY);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (TRAIN) state_next = ACCUM;
            ACCUM: begin
                if (!TRAIN)                   state_next = IDLE;
                else if (win_reg == WIN_LAST) state_next = APPLY;
            end
            APPLY:   state_next = TRAIN ? ACCUM : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (INIT) begin
            state_reg     <= IDLE;
            win_reg       <= '0;
            upd_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            win_reg       <= count_en ? win_reg + WIN_LOG2'(1) : '0;
            upd_valid_reg <= apply_en;
            busy_reg      <= (state_next != IDLE);
        end
    end

    assign upd_valid = upd_valid_reg;
    assign busy      = busy_reg;

    // Lane gi < NN is alpha[gi]; the last lane is beta.
    for (genvar gi = 0; gi < NW; gi++) begin : g_lane
        logic signed [CW-1:0] cnt_reg;
        logic [NB-1:0]        w_reg;
        logic [NB-1:0]        w_next;
        logic signed [CW-1:0] step;
        logic signed [WW-1:0] step_ext;
        logic signed [WW-1:0] diff;

        assign step     = cnt_reg >>> LR_SHIFT;
        assign step_ext = {{(WW - CW){step[CW-1]}}, step};
        assign diff     = $signed({2'b00, w_reg}) - step_ext;

        // diff spans (-2^NB, 2^(NB+1)): the top bit flags underflow, the next one overflow.
        always_comb begin
            if (diff[WW-1])      w_next = '0;
            else if (diff[WW-2]) w_next = '1;
            else                 w_next = diff[NB-1:0];
        end

        always_ff @(posedge CLK) begin
            if (INIT) begin
                cnt_reg <= '0;
                w_reg   <= W_RST;
            end else begin
                if (count_en) begin
                    if (grad_bits[gi])
                        cnt_reg <= dsign ? cnt_reg - CW'(1) : cnt_reg + CW'(1);
                end else begin
                    cnt_reg <= '0;
                end
                if (apply_en)
                    w_reg <= w_next;
            end
        end

        if (gi < NN) begin : g_alpha
            assign alpha[gi*NB +: NB] = w_reg;
        end else begin : g_beta
            assign beta = w_reg;
        end
    end

endmodule
